// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub datapath between two requesters.
// Latency: accept at cycle T -> rsp_valid from cycle T+SETTLE+1; ops spaced >= SETTLE+2 cycles.
// Backpressure: while a result waits for rsp_ready, both request readies stay low (no queueing).
module add_sub_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_cin,
    input  logic [WIDTH-1:0] as_r,
    input  logic             as_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter reload: EXEC runs SETTLE cycles, capture happens when the counter hits 0.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t           state_q;
    state_t           state_d;
    logic             ptr_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             op_sub_q;
    logic             id_q;
    logic [WIDTH-1:0] r_q;
    logic             cout_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             win_id;

    // Arbitration: a lone requester wins; under contention the pointer decides.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !ptr_q);
        grant1 = req1_valid && (!req0_valid ||  ptr_q);
    end

    // Grants are only offered while idle, so at most one ready is ever high.
    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign win_id     = req1_ready;

    // Datapath operands are only presented during EXEC; otherwise forced to zero.
    assign as_a   = (state_q == EXEC) ? op_a_q : '0;
    assign as_b   = (state_q == EXEC) ? op_b_q : '0;
    assign as_cin = (state_q == EXEC) ? op_sub_q : 1'b0;

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_r     = r_q;
    assign rsp_cout  = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = EXEC;
            EXEC: if (cnt_q == 4'd0) state_d = RESP;
            RESP: if (rsp_ready)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Operand latch, pointer update and settle countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            cnt_q    <= 4'd0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_sub_q <= 1'b0;
            id_q     <= 1'b0;
        end else if (accept) begin
            op_a_q   <= win_id ? req1_a : req0_a;
            op_b_q   <= win_id ? req1_b : req0_b;
            op_sub_q <= win_id ? req1_sub : req0_sub;
            id_q     <= win_id;
            ptr_q    <= !win_id;
            cnt_q    <= CNT_LOAD;
        end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
            cnt_q    <= cnt_q - 4'd1;
        end
    end

    // Result capture on the last settle cycle; held until overwritten by the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            cout_q <= 1'b0;
        end else if ((state_q == EXEC) && (cnt_q == 4'd0)) begin
            r_q    <= as_r;
            cout_q <= as_cout;
        end
    end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Self-checking bench: two arbiter instances (SETTLE=1 and SETTLE=3) each driving a behavioural add/sub datapath.
// Results are compared against a transaction-level model of arbitration and arithmetic.
// Backpressure is exercised by stalling rsp_ready for a number of cycles.
module tb_add_sub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic       exp_ptr = 1'b0;

    // SETTLE=1 instance signals
    logic       req0_valid = 0, req0_sub = 0, req1_valid = 0, req1_sub = 0, rsp_ready = 0;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       req0_ready, req1_ready, as_cin, as_cout, rsp_valid, rsp_id, rsp_cout;
    logic [3:0] as_a, as_b, as_r, rsp_r;

    // SETTLE=3 instance signals
    logic       s3_req0_valid = 0, s3_req0_sub = 0, s3_req1_valid = 0, s3_req1_sub = 0, s3_rsp_ready = 0;
    logic [3:0] s3_req0_a = 0, s3_req0_b = 0, s3_req1_a = 0, s3_req1_b = 0;
    logic       s3_req0_ready, s3_req1_ready, s3_as_cin, s3_as_cout, s3_rsp_valid, s3_rsp_id, s3_rsp_cout;
    logic [3:0] s3_as_a, s3_as_b, s3_as_r, s3_rsp_r;

    always #5 clk = ~clk;

    // Behavioural add_sub_df: subtract is A + ~B + 1.
    assign {as_cout, as_r}       = {1'b0, as_a} + {1'b0, (as_cin ? ~as_b : as_b)} + {4'b0, as_cin};
    assign {s3_as_cout, s3_as_r} = {1'b0, s3_as_a} + {1'b0, (s3_as_cin ? ~s3_as_b : s3_as_b)} + {4'b0, s3_as_cin};

    add_sub_arbiter #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .as_a(as_a), .as_b(as_b), .as_cin(as_cin), .as_r(as_r), .as_cout(as_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_cout(rsp_cout)
    );

    add_sub_arbiter #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s3_req0_valid), .req0_ready(s3_req0_ready), .req0_a(s3_req0_a), .req0_b(s3_req0_b), .req0_sub(s3_req0_sub),
        .req1_valid(s3_req1_valid), .req1_ready(s3_req1_ready), .req1_a(s3_req1_a), .req1_b(s3_req1_b), .req1_sub(s3_req1_sub),
        .as_a(s3_as_a), .as_b(s3_as_b), .as_cin(s3_as_cin), .as_r(s3_as_r), .as_cout(s3_as_cout),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_id(s3_rsp_id), .rsp_r(s3_rsp_r), .rsp_cout(s3_rsp_cout)
    );

    // Reference arithmetic: returns {cout, r}.
    function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic sub);
        int x;
        if (sub) begin
            x = int'(a) - int'(b);
            return {(a >= b), 4'((x + 16) % 16)};
        end
        x = int'(a) + int'(b);
        return {(x > 15), 4'(x % 16)};
    endfunction

    // Reference arbitration: lone requester wins, contention uses the pointer.
    function automatic logic ref_winner(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p;
        return v1;
    endfunction

    // One transaction on the SETTLE=1 instance; called just after a negedge.
    task automatic xact(input logic v0, input logic v1,
                        input logic [3:0] a0, input logic [3:0] b0, input logic s0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic s1,
                        input int stall,
                        output logic gid, output logic ok, output int wcyc, output int lat,
                        output logic [3:0] gr, output logic gc, output logic gi, output logic held);
        ok = 1; held = 1; wcyc = 0; lat = 0; gid = 0; gr = 0; gc = 0; gi = 0;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp_ready = 0;
        #1;
        while (!(req0_ready || req1_ready) && wcyc < 20) begin
            @(negedge clk); #1;
            wcyc++;
        end
        if (!(req0_ready || req1_ready)) begin
            ok = 0; req0_valid = 0; req1_valid = 0;
            return;
        end
        gid = req1_ready;
        @(negedge clk);
        // Scramble operands after accept: only accept-cycle values may be used.
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sub = 1'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sub = 1'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            ok = 0; req0_valid = 0; req1_valid = 0;
            return;
        end
        gr = rsp_r; gc = rsp_cout; gi = rsp_id;
        repeat (stall) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_r !== gr || rsp_cout !== gc || rsp_id !== gi ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                held = 0;
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0; req0_valid = 0; req1_valid = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        s3_req0_valid = 0; s3_req1_valid = 0; s3_rsp_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic gid, ok, gc, gi, held;
        int wcyc, lat;
        logic [3:0] gr;
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_cout, as_a, as_b, as_cin, req0_ready, req1_ready} !== 17'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {rsp_valid, rsp_id, rsp_r, rsp_cout, as_a, as_b, as_cin});
        end
        rst_n = 1; exp_ptr = 0;
        @(negedge clk);
        // Leave nonzero response/ID registers behind.
        xact(0, 1, 0, 0, 0, 4'h9, 4'h9, 0, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        exp_ptr = 0;
        total++;
        if ({ok, gi, gc, gr} !== {1'b1, 1'b1, 1'b1, 4'h2}) begin
            bad++; $display("FAIL reset_preop: got ok=%b id=%b c=%b r=%h want 1 1 1 2", ok, gi, gc, gr);
        end
        // Start an op on req0, then reset while it is in EXEC.
        req0_valid = 1; req0_a = 4'h5; req0_b = 4'h7; req0_sub = 0;
        @(negedge clk);
        req0_valid = 0;
        total++;
        if (as_a !== 4'h5 || as_b !== 4'h7) begin
            bad++; $display("FAIL reset_inexec: got a=%h b=%h want 5 7", as_a, as_b);
        end
        #3 rst_n = 0;
        #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_cout, as_a, as_b, as_cin} !== 15'd0) begin
            bad++; $display("FAIL reset_midexec: got %h want 0", {rsp_valid, rsp_id, rsp_r, rsp_cout, as_a, as_b, as_cin});
        end
        @(negedge clk);
        rst_n = 1; exp_ptr = 0;
        repeat (3) @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_discard: got rsp_valid=%b want 0", rsp_valid);
        end
        xact(1, 0, 4'h1, 4'h3, 0, 0, 0, 0, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        exp_ptr = 1;
        total++;
        if ({ok, gi, gc, gr, lat} !== {1'b1, 1'b0, 1'b0, 4'h4, 32'd2}) begin
            bad++; $display("FAIL reset_firstop: got ok=%b id=%b c=%b r=%h lat=%0d want 1 0 0 4 2", ok, gi, gc, gr, lat);
        end
    endtask

    task automatic test_single();
        logic gid, ok, gc, gi, held;
        int wcyc, lat;
        logic [3:0] gr;
        xact(0, 1, 0, 0, 0, 4'hA, 4'hC, 0, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        exp_ptr = 0;
        total++;
        if ({ok, gid, gi, gc, gr, lat} !== {1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 32'd2}) begin
            bad++; $display("FAIL single_add: got ok=%b g=%b id=%b c=%b r=%h lat=%0d want 1 1 1 1 6 2", ok, gid, gi, gc, gr, lat);
        end
        xact(0, 1, 0, 0, 0, 4'h5, 4'h2, 1, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        exp_ptr = 0;
        total++;
        if ({ok, gi, gc, gr} !== {1'b1, 1'b1, 1'b1, 4'h3}) begin
            bad++; $display("FAIL single_sub: got ok=%b id=%b c=%b r=%h want 1 1 1 3", ok, gi, gc, gr);
        end
    endtask

    task automatic test_contention();
        logic gid, ok, gc, gi, held;
        int wcyc, lat;
        logic [3:0] gr;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            xact(1, 1, 4'hF, 4'h6, 0, 4'h3, 4'h2, 1, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
            total++;
            if (ok !== 1'b1 || gid !== 1'(i % 2) || gi !== 1'(i % 2)) begin
                bad++; $display("FAIL contention_grant%0d: got ok=%b g=%b id=%b want g=%0d", i, ok, gid, gi, i % 2);
            end
            total++;
            if ({gc, gr} !== ((i % 2) ? 5'h11 : 5'h15)) begin
                bad++; $display("FAIL contention_data%0d: got c=%b r=%h want %h", i, gc, gr, (i % 2) ? 5'h11 : 5'h15);
            end
        end
        exp_ptr = 0;
    endtask

    task automatic test_backpressure();
        logic gid, ok, gc, gi, held;
        int wcyc, lat;
        logic [3:0] gr;
        xact(1, 1, 4'h8, 4'h3, 1, 4'h1, 4'h1, 0, 5, gid, ok, wcyc, lat, gr, gc, gi, held);
        total++;
        if ({ok, held, gid, gc, gr} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'h5}) begin
            bad++; $display("FAIL bp_hold: got ok=%b held=%b g=%b c=%b r=%h want 1 1 0 1 5", ok, held, gid, gc, gr);
        end
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got rsp_valid=%b want 0", rsp_valid);
        end
        xact(0, 1, 0, 0, 0, 4'h2, 4'h3, 0, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        total++;
        if ({ok, gid, gr, wcyc} !== {1'b1, 1'b1, 4'h5, 32'd0}) begin
            bad++; $display("FAIL bp_nextaccept: got ok=%b g=%b r=%h wait=%0d want 1 1 5 0", ok, gid, gr, wcyc);
        end
        exp_ptr = 0;
    endtask

    task automatic test_settle3();
        s3_req0_valid = 1; s3_req0_a = 4'hA; s3_req0_b = 4'hC; s3_req0_sub = 1;
        #1;
        total++;
        if (s3_req0_ready !== 1'b1) begin
            bad++; $display("FAIL s3_ready: got %b want 1", s3_req0_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            s3_req0_valid = 0; s3_req0_a = 4'h0; s3_req0_b = 4'h0; s3_req0_sub = 0;
            total++;
            if ({s3_as_a, s3_as_b, s3_as_cin, s3_rsp_valid} !== {4'hA, 4'hC, 1'b1, 1'b0}) begin
                bad++; $display("FAIL s3_exec%0d: got a=%h b=%h cin=%b v=%b want A C 1 0", k, s3_as_a, s3_as_b, s3_as_cin, s3_rsp_valid);
            end
        end
        @(negedge clk);
        total++;
        if ({s3_rsp_valid, s3_rsp_id, s3_rsp_cout, s3_rsp_r, s3_as_a} !== {1'b1, 1'b0, 1'b0, 4'hE, 4'h0}) begin
            bad++; $display("FAIL s3_resp: got v=%b id=%b c=%b r=%h a=%h want 1 0 0 E 0", s3_rsp_valid, s3_rsp_id, s3_rsp_cout, s3_rsp_r, s3_as_a);
        end
        s3_rsp_ready = 1;
        @(negedge clk);
        s3_rsp_ready = 0;
        total++;
        if (s3_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL s3_release: got %b want 0", s3_rsp_valid);
        end
    endtask

    task automatic test_operand_change();
        logic gid, ok, gc, gi, held;
        int wcyc, lat;
        logic [3:0] gr;
        apply_reset();
        // req1 waits with b=1 while req0 is served; operands get scrambled meanwhile.
        xact(1, 1, 4'h2, 4'h2, 0, 4'h4, 4'h1, 1, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        total++;
        if ({ok, gid, gr} !== {1'b1, 1'b0, 4'h4}) begin
            bad++; $display("FAIL opchg_first: got ok=%b g=%b r=%h want 1 0 4", ok, gid, gr);
        end
        xact(0, 1, 0, 0, 0, 4'h4, 4'h7, 1, 0, gid, ok, wcyc, lat, gr, gc, gi, held);
        total++;
        if ({ok, gi, gc, gr} !== {1'b1, 1'b1, 1'b0, 4'hD}) begin
            bad++; $display("FAIL opchg_second: got ok=%b id=%b c=%b r=%h want 1 1 0 D", ok, gi, gc, gr);
        end
        exp_ptr = 0;
    endtask

    task automatic test_random();
        logic gid, ok, gc, gi, held, v0, v1, s0, s1, ew;
        logic [3:0] a0, b0, a1, b1, gr;
        logic [4:0] exp;
        int wcyc, lat;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1;
            a0 = 4'($urandom); b0 = 4'($urandom); s0 = 1'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); s1 = 1'($urandom);
            ew = ref_winner(v0, v1, exp_ptr);
            exp = ew ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
            xact(v0, v1, a0, b0, s0, a1, b1, s1, $urandom_range(0, 2), gid, ok, wcyc, lat, gr, gc, gi, held);
            exp_ptr = !ew;
            total++;
            if ({ok, held, gid, gi, lat} !== {1'b1, 1'b1, ew, ew, 32'd2}) begin
                bad++; $display("FAIL rand%0d_ctrl: got ok=%b held=%b g=%b id=%b lat=%0d want 1 1 %b %b 2", i, ok, held, gid, gi, lat, ew, ew);
            end
            total++;
            if ({gc, gr} !== exp) begin
                bad++; $display("FAIL rand%0d_data: got c=%b r=%h want c=%b r=%h", i, gc, gr, exp[4], exp[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_settle3();
        test_operand_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
